// File: rtl/update_points_multi_if.sv
// update_points_multi_if
//   Request/response bus between the multi-point updater and an external
//   collision engine. The updater raises coll_req_out with a segment
//   description (start position, displacement, start velocity). It holds the
//   request until the engine answers with a one-cycle coll_done_in pulse and
//   the resolved result.
//
//   master : updater side   (drives request + segment, reads result)
//   slave  : engine side    (reads request + segment, drives result)
//
//   Segment (master -> slave):
//     coll_req_out                       request, held until coll_done_in
//     coll_pos_x_out / coll_pos_y_out    segment start
//     coll_dx_out / coll_dy_out          segment displacement
//     coll_vel_x_out / coll_vel_y_out    velocity at segment start
//   Result (slave -> master):
//     coll_done_in                       one-cycle result-valid pulse
//     coll_hit_in                        segment hit an obstacle
//     coll_x_new_in / coll_y_new_in      resolved end position
//     coll_x_int_in / coll_y_int_in      intersection point
//     coll_vx_in / coll_vy_in            post-bounce velocity
//     coll_ax_in / coll_ay_in            contact acceleration
interface update_points_multi_if #(
    parameter int POSITION_SIZE     = 16,
    parameter int VELOCITY_SIZE     = 16,
    parameter int ACCELERATION_SIZE = 8
);
    logic                                coll_req_out;
    logic signed [POSITION_SIZE-1:0]     coll_pos_x_out;
    logic signed [POSITION_SIZE-1:0]     coll_pos_y_out;
    logic signed [POSITION_SIZE-1:0]     coll_dx_out;
    logic signed [POSITION_SIZE-1:0]     coll_dy_out;
    logic signed [VELOCITY_SIZE-1:0]     coll_vel_x_out;
    logic signed [VELOCITY_SIZE-1:0]     coll_vel_y_out;

    logic                                coll_done_in;
    logic                                coll_hit_in;
    logic signed [POSITION_SIZE-1:0]     coll_x_new_in;
    logic signed [POSITION_SIZE-1:0]     coll_y_new_in;
    logic signed [POSITION_SIZE-1:0]     coll_x_int_in;
    logic signed [POSITION_SIZE-1:0]     coll_y_int_in;
    logic signed [VELOCITY_SIZE-1:0]     coll_vx_in;
    logic signed [VELOCITY_SIZE-1:0]     coll_vy_in;
    logic signed [ACCELERATION_SIZE-1:0] coll_ax_in;
    logic signed [ACCELERATION_SIZE-1:0] coll_ay_in;

    modport master (
        output coll_req_out, coll_pos_x_out, coll_pos_y_out, coll_dx_out, coll_dy_out,
               coll_vel_x_out, coll_vel_y_out,
        input  coll_done_in, coll_hit_in, coll_x_new_in, coll_y_new_in,
               coll_x_int_in, coll_y_int_in, coll_vx_in, coll_vy_in, coll_ax_in, coll_ay_in
    );

    modport slave (
        input  coll_req_out, coll_pos_x_out, coll_pos_y_out, coll_dx_out, coll_dy_out,
               coll_vel_x_out, coll_vel_y_out,
        output coll_done_in, coll_hit_in, coll_x_new_in, coll_y_new_in,
               coll_x_int_in, coll_y_int_in, coll_vx_in, coll_vy_in, coll_ax_in, coll_ay_in
    );
endinterface

// File: rtl/update_points_multi.sv
// update_points_multi
//   Integrates NUM_POINTS soft-body mass points for one physics step, one
//   point at a time. Each point moves by its velocity scaled by
//   dt = 2^-DT_SHIFT. The move is checked against an external collision
//   engine; on a hit, the remaining segment from the intersection point is
//   re-checked, up to MAX_PASSES requests per point. After that, the summed
//   external and contact accelerations are applied to the velocity, with
//   saturation.
//
//   Ports:
//     clk_in, rst_in                clock, asynchronous active-high reset
//     begin_in                      start a step (only honoured when idle)
//     busy_out                      step in progress
//     pos/vel/acc_{x,y}_in          per-point start state (latched on begin)
//     coll                          collision engine bus (master side)
//     new_pos_{x,y}, new_vel_{x,y}  per-point results, held until next step
//     coll_mask_out                 bit i set if point i hit at least once
//     result_out                    one-cycle pulse when the body is done
//
//   Build option:
//     COLLISION_DAMPING_EN  when defined, each accepted hit stores
//                           v - (v >>> 2) per axis (about 0.75x restitution)
//                           instead of the engine's velocity.
module update_points_multi #(
    parameter int POSITION_SIZE     = 16,
    parameter int VELOCITY_SIZE     = 16,
    parameter int ACCELERATION_SIZE = 8,
    parameter int NUM_POINTS        = 4,
    parameter int DT_SHIFT          = 0,
    parameter int MAX_PASSES        = 3
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic                                            begin_in,
    output logic                                            busy_out,
    input  logic [NUM_POINTS-1:0][POSITION_SIZE-1:0]        pos_x_in,
    input  logic [NUM_POINTS-1:0][POSITION_SIZE-1:0]        pos_y_in,
    input  logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0]        vel_x_in,
    input  logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0]        vel_y_in,
    input  logic [NUM_POINTS-1:0][ACCELERATION_SIZE-1:0]    acc_x_in,
    input  logic [NUM_POINTS-1:0][ACCELERATION_SIZE-1:0]    acc_y_in,
    update_points_multi_if.master                           coll,
    output logic [NUM_POINTS-1:0][POSITION_SIZE-1:0]        new_pos_x,
    output logic [NUM_POINTS-1:0][POSITION_SIZE-1:0]        new_pos_y,
    output logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0]        new_vel_x,
    output logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0]        new_vel_y,
    output logic [NUM_POINTS-1:0]                           coll_mask_out,
    output logic                                            result_out
);
    localparam int IDX_W  = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
    localparam int PASS_W = $clog2(MAX_PASSES + 1);
    // One external acceleration plus up to MAX_PASSES contact accelerations
    // always fit in this width, so the accumulator never overflows.
    localparam int ACC_W  = ACCELERATION_SIZE + $clog2(MAX_PASSES + 1) + 1;
    localparam int SUM_W  = ((VELOCITY_SIZE > ACC_W) ? VELOCITY_SIZE : ACC_W) + 1;

    localparam logic signed [SUM_W-1:0] VEL_MAX = SUM_W'((64'sd1 <<< (VELOCITY_SIZE - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] VEL_MIN = SUM_W'(-(64'sd1 <<< (VELOCITY_SIZE - 1)));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_FORCES,
        ST_DONE
    } state_t;

    state_t state;

    logic [NUM_POINTS-1:0][POSITION_SIZE-1:0]     pos_x_r, pos_y_r;
    logic [NUM_POINTS-1:0][VELOCITY_SIZE-1:0]     vel_x_r, vel_y_r;
    logic [NUM_POINTS-1:0][ACCELERATION_SIZE-1:0] acc_x_r, acc_y_r;

    logic [IDX_W-1:0]                idx;
    logic [PASS_W-1:0]               pass_cnt;
    logic signed [ACC_W-1:0]         acc_acc_x, acc_acc_y;
    logic                            req_r;
    logic signed [POSITION_SIZE-1:0] seg_pos_x, seg_pos_y, seg_dx, seg_dy;
    logic signed [VELOCITY_SIZE-1:0] seg_vel_x, seg_vel_y;

    // Values of the point currently being processed.
    logic signed [POSITION_SIZE-1:0]     cur_pos_x, cur_pos_y;
    logic signed [VELOCITY_SIZE-1:0]     cur_vel_x, cur_vel_y;
    logic signed [VELOCITY_SIZE-1:0]     cur_new_vel_x, cur_new_vel_y;
    logic signed [ACCELERATION_SIZE-1:0] cur_acc_x, cur_acc_y;

    assign cur_pos_x     = $signed(pos_x_r[idx]);
    assign cur_pos_y     = $signed(pos_y_r[idx]);
    assign cur_vel_x     = $signed(vel_x_r[idx]);
    assign cur_vel_y     = $signed(vel_y_r[idx]);
    assign cur_new_vel_x = $signed(new_vel_x[idx]);
    assign cur_new_vel_y = $signed(new_vel_y[idx]);
    assign cur_acc_x     = $signed(acc_x_r[idx]);
    assign cur_acc_y     = $signed(acc_y_r[idx]);

    // First segment: velocity scaled by dt and resized to position width.
    logic signed [POSITION_SIZE-1:0] load_dx, load_dy, load_new_x, load_new_y;
    assign load_dx    = POSITION_SIZE'(cur_vel_x >>> DT_SHIFT);
    assign load_dy    = POSITION_SIZE'(cur_vel_y >>> DT_SHIFT);
    assign load_new_x = cur_pos_x + load_dx;
    assign load_new_y = cur_pos_y + load_dy;

    // Follow-up segment after a hit runs from the intersection to the resolved end.
    logic signed [POSITION_SIZE-1:0] hit_dx, hit_dy;
    assign hit_dx = coll.coll_x_new_in - coll.coll_x_int_in;
    assign hit_dy = coll.coll_y_new_in - coll.coll_y_int_in;

    // Velocity stored into the result on an accepted hit.
    logic signed [VELOCITY_SIZE-1:0] hit_vx, hit_vy;
`ifdef COLLISION_DAMPING_EN
    assign hit_vx = coll.coll_vx_in - (coll.coll_vx_in >>> 2);
    assign hit_vy = coll.coll_vy_in - (coll.coll_vy_in >>> 2);
`else
    assign hit_vx = coll.coll_vx_in;
    assign hit_vy = coll.coll_vy_in;
`endif

    logic [PASS_W-1:0] pass_next;
    assign pass_next = pass_cnt + 1'b1;

    // Velocity update with the accumulated acceleration, computed wide then clamped.
    logic signed [ACC_W-1:0] acc_sh_x, acc_sh_y;
    logic signed [SUM_W-1:0] sum_x, sum_y;
    assign acc_sh_x = acc_acc_x >>> DT_SHIFT;
    assign acc_sh_y = acc_acc_y >>> DT_SHIFT;
    assign sum_x    = SUM_W'(cur_new_vel_x) + SUM_W'(acc_sh_x);
    assign sum_y    = SUM_W'(cur_new_vel_y) + SUM_W'(acc_sh_y);

    function automatic logic signed [VELOCITY_SIZE-1:0] sat_vel(input logic signed [SUM_W-1:0] v);
        if (v > VEL_MAX) begin
            return VELOCITY_SIZE'(VEL_MAX);
        end else if (v < VEL_MIN) begin
            return VELOCITY_SIZE'(VEL_MIN);
        end else begin
            return VELOCITY_SIZE'(v);
        end
    endfunction

    assign coll.coll_req_out   = req_r;
    assign coll.coll_pos_x_out = seg_pos_x;
    assign coll.coll_pos_y_out = seg_pos_y;
    assign coll.coll_dx_out    = seg_dx;
    assign coll.coll_dy_out    = seg_dy;
    assign coll.coll_vel_x_out = seg_vel_x;
    assign coll.coll_vel_y_out = seg_vel_y;

    // Step sequencer. Each point goes LOAD -> WAIT (one or more collision
    // round trips) -> FORCES; after the last point the FSM pulses result_out
    // from DONE. In WAIT, a cycle with req low is the re-arm gap between
    // chained requests. Any coll_done_in seen while req is low is dropped,
    // including a pulse that coincides with req being raised.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            pos_x_r       <= '0;
            pos_y_r       <= '0;
            vel_x_r       <= '0;
            vel_y_r       <= '0;
            acc_x_r       <= '0;
            acc_y_r       <= '0;
            idx           <= '0;
            pass_cnt      <= '0;
            acc_acc_x     <= '0;
            acc_acc_y     <= '0;
            req_r         <= 1'b0;
            seg_pos_x     <= '0;
            seg_pos_y     <= '0;
            seg_dx        <= '0;
            seg_dy        <= '0;
            seg_vel_x     <= '0;
            seg_vel_y     <= '0;
            new_pos_x     <= '0;
            new_pos_y     <= '0;
            new_vel_x     <= '0;
            new_vel_y     <= '0;
            coll_mask_out <= '0;
            busy_out      <= 1'b0;
            result_out    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    result_out <= 1'b0;
                    if (begin_in) begin
                        pos_x_r       <= pos_x_in;
                        pos_y_r       <= pos_y_in;
                        vel_x_r       <= vel_x_in;
                        vel_y_r       <= vel_y_in;
                        acc_x_r       <= acc_x_in;
                        acc_y_r       <= acc_y_in;
                        coll_mask_out <= '0;
                        idx           <= '0;
                        busy_out      <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    seg_pos_x      <= cur_pos_x;
                    seg_pos_y      <= cur_pos_y;
                    seg_vel_x      <= cur_vel_x;
                    seg_vel_y      <= cur_vel_y;
                    seg_dx         <= load_dx;
                    seg_dy         <= load_dy;
                    new_pos_x[idx] <= load_new_x;
                    new_pos_y[idx] <= load_new_y;
                    new_vel_x[idx] <= cur_vel_x;
                    new_vel_y[idx] <= cur_vel_y;
                    acc_acc_x      <= ACC_W'(cur_acc_x);
                    acc_acc_y      <= ACC_W'(cur_acc_y);
                    pass_cnt       <= '0;
                    req_r          <= 1'b1;
                    state          <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (!req_r) begin
                        req_r <= 1'b1;
                    end else if (coll.coll_done_in) begin
                        req_r    <= 1'b0;
                        pass_cnt <= pass_next;
                        if (coll.coll_hit_in) begin
                            new_pos_x[idx]     <= coll.coll_x_new_in;
                            new_pos_y[idx]     <= coll.coll_y_new_in;
                            new_vel_x[idx]     <= hit_vx;
                            new_vel_y[idx]     <= hit_vy;
                            acc_acc_x          <= acc_acc_x + ACC_W'(coll.coll_ax_in);
                            acc_acc_y          <= acc_acc_y + ACC_W'(coll.coll_ay_in);
                            coll_mask_out[idx] <= 1'b1;
                            if (pass_next < PASS_W'(MAX_PASSES)) begin
                                seg_pos_x <= coll.coll_x_int_in;
                                seg_pos_y <= coll.coll_y_int_in;
                                seg_vel_x <= coll.coll_vx_in;
                                seg_vel_y <= coll.coll_vy_in;
                                seg_dx    <= hit_dx;
                                seg_dy    <= hit_dy;
                            end else begin
                                state <= ST_FORCES;
                            end
                        end else begin
                            state <= ST_FORCES;
                        end
                    end
                end

                ST_FORCES: begin
                    new_vel_x[idx] <= sat_vel(sum_x);
                    new_vel_y[idx] <= sat_vel(sum_y);
                    if (idx == IDX_W'(NUM_POINTS - 1)) begin
                        result_out <= 1'b1;
                        busy_out   <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_LOAD;
                    end
                end

                ST_DONE: begin
                    result_out <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_update_points_multi.sv
// tb_update_points_multi
//   Directed bench for update_points_multi (4 points, dt = 1, 3 passes).
//   A scripted collision engine answers each request on its second high
//   cycle, taking responses from a queue (no-hit when the queue is empty),
//   and logs every request it sees.
module tb_update_points_multi;
    localparam int NP = 4;
    localparam int PS = 16;
    localparam int VS = 16;
    localparam int AS = 8;

    logic clk_in = 1'b0;
    logic rst_in;
    logic begin_in;
    logic busy_out;
    logic result_out;
    logic [NP-1:0][PS-1:0] pos_x_in, pos_y_in, new_pos_x, new_pos_y;
    logic [NP-1:0][VS-1:0] vel_x_in, vel_y_in, new_vel_x, new_vel_y;
    logic [NP-1:0][AS-1:0] acc_x_in, acc_y_in;
    logic [NP-1:0]         coll_mask_out;

    update_points_multi_if #(.POSITION_SIZE(PS), .VELOCITY_SIZE(VS), .ACCELERATION_SIZE(AS)) ifc ();

    update_points_multi #(
        .POSITION_SIZE(PS), .VELOCITY_SIZE(VS), .ACCELERATION_SIZE(AS),
        .NUM_POINTS(NP), .DT_SHIFT(0), .MAX_PASSES(3)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .begin_in(begin_in), .busy_out(busy_out),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
        .acc_x_in(acc_x_in), .acc_y_in(acc_y_in), .coll(ifc),
        .new_pos_x(new_pos_x), .new_pos_y(new_pos_y), .new_vel_x(new_vel_x), .new_vel_y(new_vel_y),
        .coll_mask_out(coll_mask_out), .result_out(result_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit hit;
        int xn, yn, xi, yi, vx, vy, ax, ay;
    } resp_t;

    resp_t resp_q[$];
    int    log_px[$], log_py[$], log_dx[$], log_dy[$], log_vx[$], log_vy[$];
    int    req_count = 0;
    bit    inject_done = 1'b0;
    int    checks = 0;
    int    failures = 0;

    // Collision engine model: samples 1 ns after each rising edge, logs a new
    // request, answers it one cycle later, and can fire a stray hit pulse
    // while no request is pending.
    initial begin : engine
        bit    seen;
        resp_t r;
        seen = 1'b0;
        ifc.coll_done_in  = 1'b0;
        ifc.coll_hit_in   = 1'b0;
        ifc.coll_x_new_in = '0;
        ifc.coll_y_new_in = '0;
        ifc.coll_x_int_in = '0;
        ifc.coll_y_int_in = '0;
        ifc.coll_vx_in    = '0;
        ifc.coll_vy_in    = '0;
        ifc.coll_ax_in    = '0;
        ifc.coll_ay_in    = '0;
        forever begin
            @(posedge clk_in);
            #1;
            ifc.coll_done_in = 1'b0;
            if (ifc.coll_req_out) begin
                if (!seen) begin
                    seen = 1'b1;
                    req_count++;
                    log_px.push_back(int'(ifc.coll_pos_x_out));
                    log_py.push_back(int'(ifc.coll_pos_y_out));
                    log_dx.push_back(int'(ifc.coll_dx_out));
                    log_dy.push_back(int'(ifc.coll_dy_out));
                    log_vx.push_back(int'(ifc.coll_vel_x_out));
                    log_vy.push_back(int'(ifc.coll_vel_y_out));
                end else begin
                    seen = 1'b0;
                    if (resp_q.size() > 0) r = resp_q.pop_front();
                    else r = '{default: 0};
                    ifc.coll_hit_in   = r.hit;
                    ifc.coll_x_new_in = PS'(r.xn);
                    ifc.coll_y_new_in = PS'(r.yn);
                    ifc.coll_x_int_in = PS'(r.xi);
                    ifc.coll_y_int_in = PS'(r.yi);
                    ifc.coll_vx_in    = VS'(r.vx);
                    ifc.coll_vy_in    = VS'(r.vy);
                    ifc.coll_ax_in    = AS'(r.ax);
                    ifc.coll_ay_in    = AS'(r.ay);
                    ifc.coll_done_in  = 1'b1;
                end
            end else begin
                seen = 1'b0;
                if (inject_done) begin
                    ifc.coll_hit_in   = 1'b1;
                    ifc.coll_x_new_in = PS'(999);
                    ifc.coll_y_new_in = PS'(999);
                    ifc.coll_vx_in    = VS'(77);
                    ifc.coll_vy_in    = VS'(77);
                    ifc.coll_ax_in    = AS'(50);
                    ifc.coll_ay_in    = AS'(50);
                    ifc.coll_done_in  = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkPoint(input string pre, input int i, input int px, input int py,
                              input int vx, input int vy);
        checkOutput($sformatf("%s_p%0d_pos_x", pre, i), int'($signed(new_pos_x[i])), px);
        checkOutput($sformatf("%s_p%0d_pos_y", pre, i), int'($signed(new_pos_y[i])), py);
        checkOutput($sformatf("%s_p%0d_vel_x", pre, i), int'($signed(new_vel_x[i])), vx);
        checkOutput($sformatf("%s_p%0d_vel_y", pre, i), int'($signed(new_vel_y[i])), vy);
    endtask

    task automatic setAll(input int px, input int py, input int vx, input int vy,
                          input int ax, input int ay);
        for (int i = 0; i < NP; i++) begin
            pos_x_in[i] = PS'(px);
            pos_y_in[i] = PS'(py);
            vel_x_in[i] = VS'(vx);
            vel_y_in[i] = VS'(vy);
            acc_x_in[i] = AS'(ax);
            acc_y_in[i] = AS'(ay);
        end
    endtask

    task automatic clearLogs();
        resp_q.delete();
        log_px.delete(); log_py.delete(); log_dx.delete();
        log_dy.delete(); log_vx.delete(); log_vy.delete();
        req_count = 0;
    endtask

    // Pulses begin_in across one rising edge; returns 2 ns after that edge.
    task automatic applyStimulus(input bit inject);
        @(negedge clk_in);
        begin_in    = 1'b1;
        inject_done = inject;
        @(posedge clk_in);
        #2;
        begin_in    = 1'b0;
        inject_done = 1'b0;
    endtask

    // Counts edges after the accepting edge until result_out (-1 on timeout).
    task automatic waitResult(input int stray_at, output int cycles);
        cycles = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk_in);
            #1;
            if (stray_at != 0 && n == stray_at) begin
                begin_in = 1'b1;
                for (int i = 0; i < NP; i++) pos_x_in[i] = PS'(500);
            end
            if (stray_at != 0 && n == stray_at + 1) begin_in = 1'b0;
            if (result_out) begin
                cycles = n;
                break;
            end
        end
        begin_in = 1'b0;
    endtask

    task automatic checkPulseEnd(input string pre);
        @(posedge clk_in);
        #1;
        checkOutput({pre, "_result_low"}, int'(result_out), 0);
        checkOutput({pre, "_busy_low"}, int'(busy_out), 0);
    endtask

    initial begin : main
        int cyc;
        int pulses;
        resp_t r;
        rst_in   = 1'b1;
        begin_in = 1'b0;
        setAll(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("rst_busy", int'(busy_out), 0);
        checkOutput("rst_result", int'(result_out), 0);
        checkOutput("rst_req", int'(ifc.coll_req_out), 0);
        checkOutput("rst_mask", int'(coll_mask_out), 0);
        checkOutput("rst_pos_x0", int'($signed(new_pos_x[0])), 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // No hits on any point.
        $display("[TB] no-hit step");
        clearLogs();
        setAll(10, 20, 3, -2, 1, 1);
        applyStimulus(1'b0);
        checkOutput("t1_busy", int'(busy_out), 1);
        waitResult(0, cyc);
        checkOutput("t1_latency", cyc, 16);
        checkOutput("t1_busy_at_result", int'(busy_out), 0);
        for (int i = 0; i < NP; i++) checkPoint("t1", i, 13, 18, 4, -1);
        checkOutput("t1_mask", int'(coll_mask_out), 0);
        checkOutput("t1_reqs", req_count, 4);
        checkOutput("t1_seg0_pos_x", log_px[0], 10);
        checkOutput("t1_seg0_dy", log_dy[0], -2);
        checkPulseEnd("t1");

        // Point 2 hits once, then its follow-up segment is clear.
        $display("[TB] single hit on point 2");
        clearLogs();
        setAll(10, 20, 3, -2, 1, 1);
        r = '{default: 0}; resp_q.push_back(r); resp_q.push_back(r);
        r = '{hit: 1, xn: 5, yn: 7, xi: 8, yi: 9, vx: -3, vy: 2, ax: 0, ay: 2};
        resp_q.push_back(r);
        applyStimulus(1'b0);
        waitResult(0, cyc);
        checkOutput("t2_latency", cyc, 19);
        checkPoint("t2", 2, 5, 7, -2, 5);
        checkPoint("t2", 3, 13, 18, 4, -1);
        checkOutput("t2_mask", int'(coll_mask_out), 4);
        checkOutput("t2_reqs", req_count, 5);
        checkOutput("t2_seg2_pos_x", log_px[3], 8);
        checkOutput("t2_seg2_pos_y", log_py[3], 9);
        checkOutput("t2_seg2_dx", log_dx[3], -3);
        checkOutput("t2_seg2_dy", log_dy[3], -2);
        checkOutput("t2_seg2_vx", log_vx[3], -3);
        checkOutput("t2_seg2_vy", log_vy[3], 2);
        checkPulseEnd("t2");

        // Point 1 hits on every pass; the third result must be kept.
        $display("[TB] chained hits on point 1");
        clearLogs();
        setAll(10, 20, 3, -2, 1, 1);
        r = '{default: 0}; resp_q.push_back(r);
        r = '{hit: 1, xn: 100, yn: 200, xi: 50, yi: 60, vx: 7, vy: 8, ax: 1, ay: 0};
        resp_q.push_back(r);
        r = '{hit: 1, xn: 110, yn: 210, xi: 105, yi: 205, vx: 9, vy: 10, ax: 2, ay: 1};
        resp_q.push_back(r);
        r = '{hit: 1, xn: 120, yn: 220, xi: 115, yi: 215, vx: 11, vy: -12, ax: 3, ay: -1};
        resp_q.push_back(r);
        applyStimulus(1'b0);
        waitResult(0, cyc);
        checkOutput("t3_latency", cyc, 22);
        checkPoint("t3", 1, 120, 220, 18, -11);
        checkPoint("t3", 2, 13, 18, 4, -1);
        checkOutput("t3_mask", int'(coll_mask_out), 2);
        checkOutput("t3_reqs", req_count, 6);
        checkOutput("t3_seg3_pos_x", log_px[3], 105);
        checkOutput("t3_seg3_dx", log_dx[3], 5);
        checkOutput("t3_seg3_vx", log_vx[3], 9);
        checkPulseEnd("t3");

        // Velocity saturation at both rails, plus position wrap.
        $display("[TB] saturation");
        clearLogs();
        setAll(10, 20, 3, -2, 1, 1);
        vel_x_in[0] = VS'(32766);  vel_y_in[0] = VS'(-32767);
        acc_x_in[0] = AS'(5);      acc_y_in[0] = AS'(-5);
        pos_x_in[1] = PS'(0);      pos_y_in[1] = PS'(0);
        vel_x_in[1] = VS'(32767);  vel_y_in[1] = VS'(-32768);
        acc_x_in[1] = AS'(-1);     acc_y_in[1] = AS'(1);
        applyStimulus(1'b0);
        waitResult(0, cyc);
        checkOutput("t4_latency", cyc, 16);
        checkPoint("t4", 0, -32760, -32747, 32767, -32768);
        checkPoint("t4", 1, 32767, -32768, 32766, -32767);
        checkPoint("t4", 3, 13, 18, 4, -1);
        checkPulseEnd("t4");

        // Stray done while req is still low, and begin_in pulsed mid-step.
        $display("[TB] ignored begin and stray done");
        clearLogs();
        setAll(10, 20, 3, -2, 1, 1);
        applyStimulus(1'b1);
        waitResult(6, cyc);
        checkOutput("t5_latency", cyc, 16);
        for (int i = 0; i < NP; i++) checkPoint("t5", i, 13, 18, 4, -1);
        checkOutput("t5_mask", int'(coll_mask_out), 0);
        checkOutput("t5_reqs", req_count, 4);
        checkPulseEnd("t5");

        // Reset while waiting on the collision engine.
        $display("[TB] reset during wait");
        clearLogs();
        setAll(10, 20, 3, -2, 1, 1);
        applyStimulus(1'b0);
        for (int n = 0; n < 20; n++) begin
            if (ifc.coll_req_out) break;
            @(posedge clk_in);
            #1;
        end
        checkOutput("t6_req_before", int'(ifc.coll_req_out), 1);
        checkOutput("t6_pos_before", int'($signed(new_pos_x[0])), 13);
        rst_in = 1'b1;
        #1;
        checkOutput("t6_req", int'(ifc.coll_req_out), 0);
        checkOutput("t6_busy", int'(busy_out), 0);
        checkOutput("t6_pos_x0", int'($signed(new_pos_x[0])), 0);
        checkOutput("t6_vel_x0", int'($signed(new_vel_x[0])), 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk_in);
            #1;
            if (result_out) pulses++;
        end
        checkOutput("t6_no_result", pulses, 0);
        checkOutput("t6_idle_busy", int'(busy_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
